// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcode values, the
// fetch state encoding and the instruction length / legality lookup.
package cpu_pkg;

    // Opcodes
    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_ADD     = 8'h01;
    localparam logic [7:0] OP_SUB     = 8'h02;
    localparam logic [7:0] OP_MOV_RR  = 8'h03;
    localparam logic [7:0] OP_MOV_RA  = 8'h04;
    localparam logic [7:0] OP_MOV_AR  = 8'h05;
    localparam logic [7:0] OP_MOV_IR  = 8'h06;
    localparam logic [7:0] OP_JMP     = 8'h07;
    localparam logic [7:0] OP_JB      = 8'h08;
    localparam logic [7:0] OP_JNB     = 8'h09;
    localparam logic [7:0] OP_JZ      = 8'h0C;
    localparam logic [7:0] OP_JNZ     = 8'h0D;
    localparam logic [7:0] OP_CPL     = 8'h0E;
    localparam logic [7:0] OP_CLR     = 8'h12;
    localparam logic [7:0] OP_RSHIFT  = 8'h13;
    localparam logic [7:0] OP_LSHIFT  = 8'h14;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        ST_OP    = 3'd0,
        ST_B1    = 3'd1,
        ST_B2    = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [1:0] len;
        logic       illegal;
    } insn_len_t;

    // Instruction length in bytes; unknown opcodes are treated as
    // one-byte instructions and flagged illegal.
    function automatic insn_len_t insn_len(input logic [7:0] opcode);
        insn_len_t r;
        r.len     = 2'd1;
        r.illegal = 1'b0;
        case (opcode)
            OP_NOP, OP_CPL, OP_CLR, OP_RSHIFT, OP_LSHIFT:
                r.len = 2'd1;
            OP_ADD, OP_SUB, OP_MOV_RR, OP_JMP:
                r.len = 2'd2;
            OP_MOV_RA, OP_MOV_AR, OP_MOV_IR, OP_JB, OP_JNB, OP_JZ, OP_JNZ:
                r.len = 2'd3;
            default:
                r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/insn_len_decode.sv
// Combinational length / legality lookup for one opcode byte.
module insn_len_decode
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] opcode,
    output logic [1:0]        len,
    output logic              illegal
);

    // Table lookup through the shared package function
    always_comb begin
        insn_len_t r;
        r       = insn_len(opcode[7:0]);
        len     = r.len;
        illegal = r.illegal;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads program memory one byte
// per cycle, assembles 1..3 byte instructions and offers each complete
// instruction on a valid/ready port.
// Optional feature macro: FETCH_SELFLOOP_HALT_EN (halt after a JMP to itself).
//
// Handshake: ins_valid is high only while an instruction is held; the
// ins_* outputs and pm_addr do not change while ins_valid && !ins_ready;
// a transfer happens on the rising edge where ins_valid && ins_ready.
// A redirect overrides everything; a transfer in the same cycle still
// counts as completed.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [DATA_W-1:0] pm_data,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_opcode,
    output logic [DATA_W-1:0] ins_op1,
    output logic [DATA_W-1:0] ins_op2,
    output logic [1:0]        ins_len,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_illegal,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted,
    output logic [2:0]        dbg_state
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        dec_len;
    logic              dec_illegal;
    logic              xfer;

    insn_len_decode #(.DATA_W(DATA_W)) u_len_dec (
        .opcode  (pm_data),
        .len     (dec_len),
        .illegal (dec_illegal)
    );

    assign xfer      = ins_valid && ins_ready;
    assign pm_addr   = pc;
    assign dbg_state = state;

`ifdef FETCH_SELFLOOP_HALT_EN
    logic self_loop;
    assign self_loop = (ins_opcode == DATA_W'(OP_JMP)) && (ins_op1 == DATA_W'(ins_pc));
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_OP;
        else     state <= state_nxt;
    end

    // Next-state logic; redirect wins over every state
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = ST_OP;
        end else begin
            case (state)
                ST_OP:    state_nxt = (dec_len == 2'd1) ? ST_ISSUE : ST_B1;
                ST_B1:    state_nxt = (ins_len == 2'd2) ? ST_ISSUE : ST_B2;
                ST_B2:    state_nxt = ST_ISSUE;
                ST_ISSUE: begin
                    if (xfer) begin
`ifdef FETCH_SELFLOOP_HALT_EN
                        state_nxt = self_loop ? ST_HALT : ST_OP;
`else
                        state_nxt = ST_OP;
`endif
                    end
                end
`ifdef FETCH_SELFLOOP_HALT_EN
                ST_HALT:  state_nxt = ST_HALT;
`else
                ST_HALT:  state_nxt = ST_OP;
`endif
                default:  state_nxt = ST_OP;
            endcase
        end
    end

    // Handshake and status outputs decoded from the state register
    always_comb begin
        ins_valid = (state == ST_ISSUE);
`ifdef FETCH_SELFLOOP_HALT_EN
        halted    = (state == ST_HALT);
`else
        halted    = 1'b0;
`endif
    end

    // PC and instruction assembly; PC wraps naturally at 2^ADDR_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            ins_opcode  <= '0;
            ins_op1     <= '0;
            ins_op2     <= '0;
            ins_len     <= 2'd1;
            ins_pc      <= '0;
            ins_illegal <= 1'b0;
        end else if (redirect_valid) begin
            pc      <= redirect_addr;
            ins_op1 <= '0;
            ins_op2 <= '0;
        end else begin
            case (state)
                ST_OP: begin
                    ins_opcode  <= pm_data;
                    ins_pc      <= pc;
                    ins_len     <= dec_len;
                    ins_illegal <= dec_illegal;
                    ins_op1     <= '0;
                    ins_op2     <= '0;
                    pc          <= pc + ADDR_W'(1);
                end
                ST_B1: begin
                    ins_op1 <= pm_data;
                    pc      <= pc + ADDR_W'(1);
                end
                ST_B2: begin
                    ins_op2 <= pm_data;
                    pc      <= pc + ADDR_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
